// File: rtl/phy_mdio_config.sv
// Autonomous Clause-22 MDIO master: writes BMCR, then reads status/ID registers after reset.
// Optional: define PHY_CFG_MDC_GATE_EN to hold mdc low once configuration is done.
module phy_mdio_config #(
  parameter logic [1:0] SPEED      = 2'b01,
  parameter int         MODULE_CLK = 50_000_000,
  parameter int         MDC_CLK    = 2_000,
  parameter int         REG2CONFIG = 2,
  parameter logic [4:0] PHY_ADDR   = 5'b00001
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] read_data,
  output logic        phy_config_done,
  output logic        mdc,
  inout  wire         mdio
);

  localparam int HALF_RAW = MODULE_CLK / (2 * MDC_CLK);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int NCFG     = (REG2CONFIG < 1) ? 1 : ((REG2CONFIG > 4) ? 4 : REG2CONFIG);
  localparam logic [1:0] SPD = (SPEED == 2'b11) ? 2'b10 : SPEED;
  // Full duplex, autoneg off, speed select bits 13 (LSB) and 6 (MSB).
  localparam logic [15:0] BMCR = {2'b00, SPD[0], 4'b0000, 1'b1, 1'b0, SPD[1], 6'b000000};

  typedef enum logic [3:0] {IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, GAP, DONE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_mdc;
  logic [1:0]  r_idx;
  logic [5:0]  r_bit;
  logic        r_gap;
  logic        r_oe;
  logic        r_out;
  logic [14:0] r_sh;
  logic [15:0] r_read_data;
  logic        r_done;

  logic        w_wrap, w_fall_en, w_rise_en, w_gate, w_rd;
  logic [5:0]  w_nbit;
  logic [63:0] w_frame;
  state_t      w_nstate;

  assign w_wrap    = (r_cnt == CW'(HALF - 1));
  assign w_fall_en = w_wrap & r_mdc;
  assign w_rise_en = w_wrap & ~r_mdc;
`ifdef PHY_CFG_MDC_GATE_EN
  assign w_gate    = (r_state == DONE);
`else
  assign w_gate    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_gate) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Entry 0 is the BMCR write; entries 1..3 read registers 1..3 (data field unused on reads).
  assign w_rd    = (r_idx != 2'd0);
  assign w_frame = {32'hFFFF_FFFF, 2'b01, (w_rd ? 2'b10 : 2'b01), PHY_ADDR,
                    {3'b000, r_idx}, 2'b10, (w_rd ? 16'h0000 : BMCR)};
  assign w_nbit  = r_bit + 6'd1;

  always_comb begin
    w_nstate = DATA;
    if      (w_nbit < 6'd32) w_nstate = PRE;
    else if (w_nbit < 6'd34) w_nstate = ST;
    else if (w_nbit < 6'd36) w_nstate = OP;
    else if (w_nbit < 6'd41) w_nstate = PHYAD;
    else if (w_nbit < 6'd46) w_nstate = REGAD;
    else if (w_nbit < 6'd48) w_nstate = TA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_bit       <= 6'd0;
      r_gap       <= 1'b0;
      r_oe        <= 1'b0;
      r_out       <= 1'b0;
      r_sh        <= '0;
      r_read_data <= 16'h0000;
      r_done      <= 1'b0;
    end else begin
      if (w_rise_en && r_state == DATA && w_rd) begin
        r_sh <= {r_sh[13:0], mdio};
        if (r_bit == 6'd63) r_read_data <= {r_sh, mdio};
      end
      if (w_fall_en) begin
        case (r_state)
          IDLE: begin
            r_state <= PRE;
            r_bit   <= 6'd0;
            r_oe    <= 1'b1;
            r_out   <= 1'b1;
          end
          GAP: begin
            if (r_gap) begin
              r_gap <= 1'b0;
              if (int'(r_idx) + 1 < NCFG) begin
                r_idx   <= r_idx + 2'd1;
                r_state <= PRE;
                r_bit   <= 6'd0;
                r_oe    <= 1'b1;
                r_out   <= 1'b1;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_gap <= 1'b1;
            end
          end
          DONE: ;
          default: begin
            if (r_bit == 6'd63) begin
              r_state <= GAP;
              r_oe    <= 1'b0;
              r_gap   <= 1'b0;
            end else begin
              r_bit   <= w_nbit;
              r_state <= w_nstate;
              // Reads hand the bus to the PHY from the turnaround onward.
              r_oe    <= ~(w_rd && (w_nbit >= 6'd46));
              r_out   <= w_frame[6'd63 - w_nbit];
            end
          end
        endcase
      end
    end
  end

  assign mdc             = r_mdc;
  assign mdio            = r_oe ? r_out : 1'bz;
  assign read_data       = r_read_data;
  assign phy_config_done = r_done;

endmodule

// File: tb/tb_phy_mdio_config.sv
// Bench for phy_mdio_config: three configurations, mdio pull-ups, a positional PHY read responder.
`timescale 1ns/1ps
module tb_phy_mdio_config;

  localparam int MCLK = 50_000_000;
  localparam int MDCF = 5_000_000;
  localparam int HALF = 5;
  localparam int FL   = 66;
  localparam int MAXS = 1024;
  localparam logic [1:0] SP0 = 2'b01, SP1 = 2'b10, SP2 = 2'b11;
  localparam int N0 = 2, N1 = 4, N2 = 0;

  logic clk, rst_n;
  initial clk = 1'b0;
  always #10 clk = ~clk;

  wire mdio0, mdio1, mdio2;
  pullup (mdio0);
  pullup (mdio1);
  pullup (mdio2);
  logic mdc0, mdc1, mdc2, done0, done1, done2;
  logic [15:0] rd0, rd1, rd2;
  logic phy_oe, phy_d;
  assign mdio1 = phy_oe ? phy_d : 1'bz;

  phy_mdio_config #(.SPEED(SP0), .MODULE_CLK(MCLK), .MDC_CLK(MDCF), .REG2CONFIG(N0), .PHY_ADDR(5'b00001))
    u_dut0 (.clk(clk), .rst_n(rst_n), .read_data(rd0), .phy_config_done(done0), .mdc(mdc0), .mdio(mdio0));
  phy_mdio_config #(.SPEED(SP1), .MODULE_CLK(MCLK), .MDC_CLK(MDCF), .REG2CONFIG(N1), .PHY_ADDR(5'b00001))
    u_dut1 (.clk(clk), .rst_n(rst_n), .read_data(rd1), .phy_config_done(done1), .mdc(mdc1), .mdio(mdio1));
  phy_mdio_config #(.SPEED(SP2), .MODULE_CLK(MCLK), .MDC_CLK(MDCF), .REG2CONFIG(N2), .PHY_ADDR(5'b00001))
    u_dut2 (.clk(clk), .rst_n(rst_n), .read_data(rd2), .phy_config_done(done2), .mdc(mdc2), .mdio(mdio2));

  logic [2:0]  mdc_v, mdio_v, done_v;
  logic [15:0] rd_v [3];
  assign mdc_v  = {mdc2, mdc1, mdc0};
  assign mdio_v = {mdio2, mdio1, mdio0};
  assign done_v = {done2, done1, done0};
  always_comb begin
    rd_v[0] = rd0;
    rd_v[1] = rd1;
    rd_v[2] = rd2;
  end

  typedef struct {
    logic [1:0]  speed;
    int          reg2cfg;
    logic [15:0] bmcr;
  } vec_t;
  vec_t vt [3];

  logic        s_bit  [3][MAXS];
  logic        s_done [3][MAXS];
  logic [15:0] s_rd   [3][MAXS];
  int          s_n;
  logic [15:0] phy_val [4];

  int checks, fails;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nframes(input int r);
    return (r < 1) ? 1 : ((r > 4) ? 4 : r);
  endfunction

  // Records every MDC rising edge; PHY on dut1 answers read data slots by stream position.
  task automatic monitor();
    int n, f, b;
    forever begin
      @(posedge mdc1);
      #1;
      if (s_n < MAXS) begin
        for (int g = 0; g < 3; g++) begin
          s_bit[g][s_n]  = mdio_v[g];
          s_done[g][s_n] = done_v[g];
          s_rd[g][s_n]   = rd_v[g];
        end
        s_n++;
      end
      @(negedge mdc1);
      #1;
      n = s_n;
      phy_oe = 1'b0;
      if (n >= 1) begin
        f = (n - 1) / FL;
        b = (n - 1) % FL;
        if (f >= 1 && f <= 3 && b >= 48 && b <= 63) begin
          phy_oe = 1'b1;
          phy_d  = phy_val[f][63 - b];
        end
      end
    end
  endtask

  task automatic wait_s(input int need, input string what);
    int t;
    t = 0;
    while (s_n < need && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk({what, " sample budget"}, 64'(s_n >= need), 64'd1);
  endtask

  task automatic check_streams(input int ph);
    int base, nf;
    logic [63:0] got, exp;
    logic [15:0] dexp, prev;
    logic rdf;
    for (int g = 0; g < 3; g++) begin
      nf   = nframes(vt[g].reg2cfg);
      prev = 16'h0000;
      base = 1;
      chk($sformatf("p%0d dut%0d idle bit", ph, g), 64'(s_bit[g][0]), 64'd1);
      for (int f = 0; f < nf; f++) begin
        base = 1 + FL * f;
        rdf  = (f != 0);
        for (int b = 0; b < 64; b++) got[63 - b] = s_bit[g][base + b];
        dexp = rdf ? ((g == 1) ? phy_val[f] : 16'hFFFF) : vt[g].bmcr;
        exp  = {32'hFFFF_FFFF, 2'b01, (rdf ? 2'b10 : 2'b01), 5'b00001, 5'(f),
                (rdf ? 2'b11 : 2'b10), dexp};
        chk($sformatf("p%0d dut%0d spd%b frame%0d", ph, g, vt[g].speed, f), got, exp);
        chk($sformatf("p%0d dut%0d gap%0d", ph, g, f),
            64'({s_bit[g][base + 64], s_bit[g][base + 65]}), 64'd3);
        chk($sformatf("p%0d dut%0d read_data before end f%0d", ph, g, f), 64'(s_rd[g][base + 62]), 64'(prev));
        if (rdf) prev = dexp;
        chk($sformatf("p%0d dut%0d read_data at end f%0d", ph, g, f), 64'(s_rd[g][base + 63]), 64'(prev));
      end
      chk($sformatf("p%0d dut%0d done not early", ph, g), 64'(s_done[g][base + 65]), 64'd0);
    end
  endtask

  task automatic check_done(input int ph);
    repeat (40) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("p%0d dut%0d done", ph, g), 64'(done_v[g]), 64'd1);
  endtask

  initial begin
    int c, tog, need, b, mx;
    logic last;
    logic [15:0] bm;
    checks = 0;
    fails  = 0;
    phy_oe = 1'b0;
    phy_d  = 1'b0;
    s_n    = 0;
    rst_n  = 1'b0;
    vt[0] = '{speed: SP0, reg2cfg: N0, bmcr: 16'h2100};
    vt[1] = '{speed: SP1, reg2cfg: N1, bmcr: 16'h0140};
    vt[2] = '{speed: SP2, reg2cfg: N2, bmcr: 16'h0140};
    phy_val[0] = 16'h0000;
    phy_val[1] = 16'h786D;
    phy_val[2] = 16'($urandom);
    phy_val[3] = 16'($urandom);
    mx = 0;
    for (int g = 0; g < 3; g++) if (nframes(vt[g].reg2cfg) > mx) mx = nframes(vt[g].reg2cfg);
    need = 1 + FL * mx;
    fork monitor(); join_none

    #100;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset dut%0d mdc", g), 64'(mdc_v[g]), 64'd0);
      chk($sformatf("reset dut%0d mdio released", g), 64'(mdio_v[g]), 64'd1);
      chk($sformatf("reset dut%0d read_data", g), 64'(rd_v[g]), 64'd0);
      chk($sformatf("reset dut%0d done", g), 64'(done_v[g]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    c = 0;
    while (!mdc1 && c < 100) begin @(posedge clk); #1; c++; end
    chk("first mdc rise cycles", 64'(c), 64'(HALF));
    c = 0;
    while (mdc1 && c < 100) begin @(posedge clk); #1; c++; end
    while (!mdc1 && c < 100) begin @(posedge clk); #1; c++; end
    chk("mdc period cycles", 64'(c), 64'(2 * HALF));

    wait_s(need, "phase1");
    check_streams(1);
    check_done(1);

    tog  = 0;
    last = mdc2;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mdc2 != last) tog++;
      last = mdc2;
    end
`ifdef PHY_CFG_MDC_GATE_EN
    chk("mdc gated after done", 64'({mdc2, 7'(tog)}), 64'd0);
`else
    chk("mdc free-running after done", 64'(tog), 64'd8);
`endif

    // Asynchronous reset from the done state clears held results immediately.
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk("async reset read_data", 64'(rd1), 64'd0);
    chk("async reset done", 64'(done1), 64'd0);
    #100;
    phy_val[2] = 16'($urandom);
    phy_val[3] = 16'($urandom);
    s_n = 0;
    @(negedge clk);
    rst_n = 1'b1;

    bm = vt[0].bmcr;
    do b = int'($urandom_range(0, 15)); while (bm[15 - b]);
    wait_s(2 + 48 + b, "mid-frame");
    #3;
    chk("dut0 drives data bit before reset", 64'(mdio0), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset mdio released", 64'(mdio0), 64'd1);
    chk("mid-frame reset mdc low", 64'(mdc0), 64'd0);
    chk("mid-frame reset done", 64'(done0), 64'd0);
    #50;
    s_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_s(need, "phase2");
    check_streams(2);
    check_done(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
